axis_capture_ram: RTL



---
 rtl/axis_capture_ram_if.sv | 43 ++++
 rtl/axis_capture_ram.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axis_capture_ram_if.sv
// Bundle of the stream sink and native memory-port signals of axis_capture_ram.
// The master modport is the stream source plus the register/RAM bus driver; the slave modport is the capture block.
interface axis_capture_ram_if #(
    parameter int G_AXI_DATAWIDTH  = 32,
    parameter int G_AXIS_DATAWIDTH = 32,
    parameter int G_ADDRWIDTH      = 11,
    parameter int G_WSTRB          = ((G_AXI_DATAWIDTH - 1) / 8) + 1
);
    logic [G_AXIS_DATAWIDTH-1:0] s_axis_tdata;
    logic                        s_axis_tvalid;
    logic                        s_axis_tlast;
    logic                        s_axis_tready;

    logic                        rd;
    logic [G_ADDRWIDTH-1:0]      raddr;
    logic [G_AXI_DATAWIDTH-1:0]  rdata;
    logic                        rvalid;

    logic                        wr;
    logic [G_ADDRWIDTH-1:0]      waddr;
    logic [G_AXI_DATAWIDTH-1:0]  wdata;
    logic [G_WSTRB-1:0]          wstrb;

    logic                        done;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        output rd, raddr,
        input  rdata, rvalid,
        output wr, waddr, wdata, wstrb,
        input  done
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        input  rd, raddr,
        output rdata, rvalid,
        input  wr, waddr, wdata, wstrb,
        output done
    );
endinterface

// File: rtl/axis_capture_ram.sv
// Captures one AXI-Stream frame into a block RAM; software arms it and reads the frame back over the memory port.
// Optional feature macro AXIS_CAPTURE_DROP_EN: accept and count (DROPCNT) beats that arrive while idle or done.
module axis_capture_ram #(
    parameter int G_AXI_DATAWIDTH  = 32,
    parameter int G_AXIS_DATAWIDTH = 32,
    parameter int G_MEMDEPTH       = 1024,
    parameter int G_ADDRWIDTH      = $clog2(G_MEMDEPTH) + 1,
    parameter int G_WSTRB          = ((G_AXI_DATAWIDTH - 1) / 8) + 1
) (
    input  logic              clk,
    input  logic              rst,
    axis_capture_ram_if.slave bus
);
    localparam int IDX_W = G_ADDRWIDTH - 1;

    localparam logic [IDX_W-1:0]       REG_CTRL    = IDX_W'(0);
    localparam logic [IDX_W-1:0]       REG_STATUS  = IDX_W'(1);
    localparam logic [IDX_W-1:0]       REG_LEN     = IDX_W'(2);
    localparam logic [IDX_W-1:0]       REG_DROPCNT = IDX_W'(3);
    localparam logic [G_ADDRWIDTH-1:0] DEPTH_L     = G_ADDRWIDTH'(G_MEMDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       tready_q;
    logic                       done_q;
    logic [G_ADDRWIDTH-1:0]     len;
    logic                       overflow;
`ifdef AXIS_CAPTURE_DROP_EN
    logic [15:0]                dropcnt;
`endif

    logic                       ctrl_wr;
    logic                       arm_req;
    logic                       abort_req;
    logic                       arm_go;
    logic                       beat;
    logic                       capturing;
    logic                       ram_we;

    logic [G_AXI_DATAWIDTH-1:0] mem [G_MEMDEPTH];
    logic [G_AXI_DATAWIDTH-1:0] ram_q;
    logic [G_AXI_DATAWIDTH-1:0] reg_rd;
    logic [G_AXI_DATAWIDTH-1:0] reg_q;
    logic                       sel_ram;
    logic                       rvalid_q;
    logic                       unused_bits;

    assign ctrl_wr   = bus.wr && !bus.waddr[G_ADDRWIDTH-1] &&
                       (bus.waddr[IDX_W-1:0] == REG_CTRL) && bus.wstrb[0];
    assign arm_req   = ctrl_wr && bus.wdata[0];
    assign abort_req = ctrl_wr && bus.wdata[1];
    assign capturing = (state == S_ARMED) || (state == S_CAPTURE);
    assign arm_go    = arm_req && !abort_req && !capturing;
    assign beat      = bus.s_axis_tvalid && tready_q;
    // Past G_MEMDEPTH words the beat is still accepted, just not stored.
    assign ram_we    = beat && capturing && (len != DEPTH_L);

    // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        if (abort_req) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (arm_req) state_nxt = S_ARMED;
                S_ARMED, S_CAPTURE: begin
                    if (beat) state_nxt = bus.s_axis_tlast ? S_DONE : S_CAPTURE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tready_q <= 1'b0;
            done_q   <= 1'b0;
            len      <= '0;
            overflow <= 1'b0;
`ifdef AXIS_CAPTURE_DROP_EN
            dropcnt  <= '0;
`endif
        end else begin
            state  <= state_nxt;
            done_q <= (state_nxt == S_DONE);
`ifdef AXIS_CAPTURE_DROP_EN
            tready_q <= 1'b1;
`else
            tready_q <= (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
`endif
            if (arm_go) begin
                len      <= '0;
                overflow <= 1'b0;
`ifdef AXIS_CAPTURE_DROP_EN
                dropcnt  <= '0;
`endif
            end else if (beat && capturing) begin
                if (len == DEPTH_L) overflow <= 1'b1;
                else                len      <= len + G_ADDRWIDTH'(1);
            end
`ifdef AXIS_CAPTURE_DROP_EN
            else if (beat && (dropcnt != 16'hFFFF)) begin
                dropcnt <= dropcnt + 16'd1;
            end
`endif
        end
    end

    // NOTE: the capture RAM and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) mem[len[IDX_W-1:0]] <= G_AXI_DATAWIDTH'(bus.s_axis_tdata);
        if (bus.rd) ram_q <= mem[bus.raddr[IDX_W-1:0]];
    end

    always_comb begin
        reg_rd = '0;
        case (bus.raddr[IDX_W-1:0])
            REG_STATUS:  reg_rd = G_AXI_DATAWIDTH'({overflow, state == S_DONE, capturing});
            REG_LEN:     reg_rd = G_AXI_DATAWIDTH'(len);
`ifdef AXIS_CAPTURE_DROP_EN
            REG_DROPCNT: reg_rd = G_AXI_DATAWIDTH'(dropcnt);
`else
            REG_DROPCNT: reg_rd = '0;
`endif
            default:     reg_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            sel_ram  <= 1'b0;
            reg_q    <= '0;
        end else begin
            rvalid_q <= bus.rd;
            if (bus.rd) begin
                sel_ram <= bus.raddr[G_ADDRWIDTH-1];
                reg_q   <= reg_rd;
            end
        end
    end

    assign bus.rdata         = sel_ram ? ram_q : reg_q;
    assign bus.rvalid        = rvalid_q;
    assign bus.s_axis_tready = tready_q;
    assign bus.done          = done_q;

    // Only CTRL bits [1:0] and strobe [0] carry meaning.
    assign unused_bits = &{1'b0, bus.wdata, bus.wstrb};
endmodule
